mem_port_arbiter: RTL and testbench

//  Shares the single-port unified memory between instruction fetch (IF) and load/store (LS).

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/mem_port_arbiter_pick.sv | 33 +++
 rtl/mem_port_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
package mem_arb_pkg;

    // Arbiter FSM: IDLE = port free, WAIT = one access outstanding.
    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } arb_state_t;

    // Port owner; encoding matches addr_sel (0 = IF, 1 = LS).
    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_t;

    localparam int LAT_CNT_W   = 4;
    localparam int MEM_LAT_MAX = 15;

endpackage : mem_arb_pkg

// File: rtl/mem_port_arbiter_pick.sv
// Combinational winner selection between IF and LS.
// ARB_ROUND_ROBIN_EN selects alternating priority; otherwise LS wins unless
// the IF starvation guard has tripped.
module arb_pick
    import mem_arb_pkg::*;
(
    input  logic   if_req,
    input  logic   ls_req,
`ifdef ARB_ROUND_ROBIN_EN
    input  owner_t last_owner,
`else
    input  logic   starve_hit,
`endif
    output owner_t winner,
    output logic   any_grant
);

    // Single requester wins outright; contention resolved by the priority policy.
    always_comb begin
        winner    = OWN_IF;
        any_grant = if_req | ls_req;
        if (if_req && ls_req) begin
`ifdef ARB_ROUND_ROBIN_EN
            winner = (last_owner == OWN_IF) ? OWN_LS : OWN_IF;
`else
            winner = starve_hit ? OWN_IF : OWN_LS;
`endif
        end else if (ls_req) begin
            winner = OWN_LS;
        end
    end

endmodule : arb_pick

// File: rtl/mem_port_arbiter.sv
// Single-port unified memory arbiter between instruction fetch (IF) and
// load/store (LS). Grants are combinational in the arbitration cycle, the
// response returns MEM_LAT cycles later, and a new grant may issue in the
// response cycle so back-to-back accesses run without a bubble.
// Optional feature macro: ARB_ROUND_ROBIN_EN (alternating priority instead of
// fixed LS priority with the IF starvation guard).
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_gnt,
    output logic              ls_rvalid,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              addr_sel,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    // Elaboration-time range checks on the configuration.
    if (MEM_LAT < 1 || MEM_LAT > MEM_LAT_MAX) begin : g_bad_mem_lat
        $error("mem_port_arbiter: MEM_LAT must be in 1..15");
    end
    if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
        $error("mem_port_arbiter: STARVE_MAX must be in 1..15");
    end

    localparam logic [LAT_CNT_W-1:0] LAT_INIT = LAT_CNT_W'(MEM_LAT);
    localparam logic [LAT_CNT_W-1:0] LAT_ONE  = LAT_CNT_W'(1);

    arb_state_t           state;
    logic [LAT_CNT_W-1:0] lat_cnt;
    owner_t               owner;      // current/last granted requester
    logic                 write_q;    // outstanding access is an LS write

    owner_t               winner;
    logic                 any_grant;
    logic                 last_cycle; // WAIT with the response due this cycle
    logic                 arb_window; // cycle in which a new grant may issue
    logic                 grant;

    // Response cycle and arbitration window; held off while reset is asserted
    // so no combinational output can toggle during reset.
    always_comb begin
        last_cycle = rst_n && (state == WAIT) && (lat_cnt == LAT_ONE);
        arb_window = rst_n && ((state == IDLE) || last_cycle);
        grant      = arb_window && any_grant;
    end

`ifdef ARB_ROUND_ROBIN_EN

    arb_pick u_pick (
        .if_req     (if_req),
        .ls_req     (ls_req),
        .last_owner (owner),
        .winner     (winner),
        .any_grant  (any_grant)
    );

`else

    logic [LAT_CNT_W-1:0] starve_cnt;
    logic                 starve_hit;

    localparam logic [LAT_CNT_W-1:0] STARVE_LIM = LAT_CNT_W'(STARVE_MAX);

    // Starvation guard: IF wins the next contention once it has lost STARVE_MAX times.
    always_comb begin
        starve_hit = (starve_cnt == STARVE_LIM);
    end

    // Count IF losses at grant time; any IF grant clears the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (grant) begin
            if (winner == OWN_IF) begin
                starve_cnt <= '0;
            end else if (if_req && !starve_hit) begin
                starve_cnt <= starve_cnt + LAT_CNT_W'(1);
            end
        end
    end

    arb_pick u_pick (
        .if_req     (if_req),
        .ls_req     (ls_req),
        .starve_hit (starve_hit),
        .winner     (winner),
        .any_grant  (any_grant)
    );

`endif

    // Arbiter FSM with latency counter; a grant always (re)loads the counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            lat_cnt <= '0;
            owner   <= OWN_IF;
            write_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant) begin
                        state   <= WAIT;
                        lat_cnt <= LAT_INIT;
                        owner   <= winner;
                        write_q <= (winner == OWN_LS) && ls_we;
                    end
                end
                WAIT: begin
                    if (lat_cnt == LAT_ONE) begin
                        if (grant) begin
                            lat_cnt <= LAT_INIT;
                            owner   <= winner;
                            write_q <= (winner == OWN_LS) && ls_we;
                        end else begin
                            state   <= IDLE;
                            lat_cnt <= '0;
                            write_q <= 1'b0;
                        end
                    end else begin
                        lat_cnt <= lat_cnt - LAT_CNT_W'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    lat_cnt <= '0;
                end
            endcase
        end
    end

    // Memory port and grant drive; addr_sel follows the winner only in grant cycles.
    always_comb begin
        if_gnt    = grant && (winner == OWN_IF);
        ls_gnt    = grant && (winner == OWN_LS);
        mem_en    = grant;
        mem_we    = ls_gnt && ls_we;
        mem_addr  = '0;
        mem_wdata = '0;
        if (if_gnt) begin
            mem_addr = if_addr;
        end else if (ls_gnt) begin
            mem_addr  = ls_addr;
            mem_wdata = ls_wdata;
        end
        if (grant) begin
            addr_sel = (winner == OWN_LS);
        end else begin
            addr_sel = rst_n && (owner == OWN_LS);
        end
    end

    // Response return to the owner of the outstanding access.
    always_comb begin
        if_rvalid = last_cycle && (owner == OWN_IF);
        ls_rvalid = last_cycle && (owner == OWN_LS);
        if_rdata  = if_rvalid ? mem_rdata : '0;
        ls_rdata  = (ls_rvalid && !write_q) ? mem_rdata : '0;
        busy      = rst_n && (state == WAIT);
    end

endmodule : mem_port_arbiter

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (MEM_LAT=2, STARVE_MAX=4).
module tb_mem_port_arbiter;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int MEM_LAT    = 2;
    localparam int STARVE_MAX = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;
    logic              ls_req;
    logic              ls_we;
    logic [ADDR_W-1:0] ls_addr;
    logic [DATA_W-1:0] ls_wdata;
    logic              ls_gnt;
    logic              ls_rvalid;
    logic [DATA_W-1:0] ls_rdata;
    logic              addr_sel;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;

    int n_checks = 0;
    int n_fail   = 0;

    mem_port_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .MEM_LAT    (MEM_LAT),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .ls_req    (ls_req),
        .ls_we     (ls_we),
        .ls_addr   (ls_addr),
        .ls_wdata  (ls_wdata),
        .ls_gnt    (ls_gnt),
        .ls_rvalid (ls_rvalid),
        .ls_rdata  (ls_rdata),
        .addr_sel  (addr_sel),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_reqs();
        if_req = 1'b0;
        ls_req = 1'b0;
        ls_we  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [9:0] seq_ls;
        logic       exp_ls;

`ifdef ARB_ROUND_ROBIN_EN
        seq_ls = 10'b01_0101_0101;   // bit k: grant k goes to LS
`else
        seq_ls = 10'b01_1110_1111;
`endif

        // Reset with both requests pending: everything must stay quiet.
        rst_n     = 1'b0;
        if_req    = 1'b1;
        ls_req    = 1'b1;
        ls_we     = 1'b1;
        if_addr   = 32'h10;
        ls_addr   = 32'h20;
        ls_wdata  = 32'h30;
        mem_rdata = 32'h0;
        tick();
        tick();
        chk1("rst if_gnt", if_gnt, 1'b0);
        chk1("rst ls_gnt", ls_gnt, 1'b0);
        chk1("rst mem_en", mem_en, 1'b0);
        chk1("rst mem_we", mem_we, 1'b0);
        chk1("rst addr_sel", addr_sel, 1'b0);
        chk1("rst busy", busy, 1'b0);
        chk32("rst mem_addr", mem_addr, 32'h0);
        chk32("rst mem_wdata", mem_wdata, 32'h0);
        clear_reqs();
        rst_n = 1'b1;
        tick();

        // IF-only read at 0x100.
        if_req    = 1'b1;
        if_addr   = 32'h100;
        mem_rdata = 32'hDEADBEEF;
        #1;
        chk1("if T0 if_gnt", if_gnt, 1'b1);
        chk1("if T0 ls_gnt", ls_gnt, 1'b0);
        chk1("if T0 mem_en", mem_en, 1'b1);
        chk1("if T0 mem_we", mem_we, 1'b0);
        chk32("if T0 mem_addr", mem_addr, 32'h100);
        chk1("if T0 addr_sel", addr_sel, 1'b0);
        chk1("if T0 busy", busy, 1'b0);
        tick();
        if_req = 1'b0;
        #1;
        chk1("if T1 if_rvalid", if_rvalid, 1'b0);
        chk1("if T1 mem_en", mem_en, 1'b0);
        chk1("if T1 busy", busy, 1'b1);
        tick();
        chk1("if T2 if_rvalid", if_rvalid, 1'b1);
        chk32("if T2 if_rdata", if_rdata, 32'hDEADBEEF);
        chk1("if T2 ls_rvalid", ls_rvalid, 1'b0);
        tick();
        chk1("if T3 busy", busy, 1'b0);
        chk1("if T3 if_rvalid", if_rvalid, 1'b0);

        // LS write 0x12345678 to 0x40.
        ls_req   = 1'b1;
        ls_we    = 1'b1;
        ls_addr  = 32'h40;
        ls_wdata = 32'h12345678;
        #1;
        chk1("wr T0 ls_gnt", ls_gnt, 1'b1);
        chk1("wr T0 mem_en", mem_en, 1'b1);
        chk1("wr T0 mem_we", mem_we, 1'b1);
        chk1("wr T0 addr_sel", addr_sel, 1'b1);
        chk32("wr T0 mem_addr", mem_addr, 32'h40);
        chk32("wr T0 mem_wdata", mem_wdata, 32'h12345678);
        tick();
        clear_reqs();
        #1;
        chk1("wr T1 addr_sel", addr_sel, 1'b1);
        chk1("wr T1 ls_rvalid", ls_rvalid, 1'b0);
        tick();
        chk1("wr T2 ls_rvalid", ls_rvalid, 1'b1);
        chk32("wr T2 ls_rdata", ls_rdata, 32'h0);
        tick();
        chk1("wr T3 busy", busy, 1'b0);
        chk1("wr T3 addr_sel hold", addr_sel, 1'b1);

        // Back-to-back IF: next request waits through WAIT and is granted in the rvalid cycle.
        if_req    = 1'b1;
        if_addr   = 32'h180;
        mem_rdata = 32'hA5A50001;
        #1;
        chk1("b2b T0 if_gnt", if_gnt, 1'b1);
        chk1("b2b T0 addr_sel", addr_sel, 1'b0);
        tick();
        if_addr = 32'h184;
        #1;
        chk1("b2b T1 no gnt in WAIT", if_gnt, 1'b0);
        chk1("b2b T1 mem_en", mem_en, 1'b0);
        tick();
        chk1("b2b T2 if_rvalid", if_rvalid, 1'b1);
        chk32("b2b T2 if_rdata", if_rdata, 32'hA5A50001);
        chk1("b2b T2 if_gnt", if_gnt, 1'b1);
        chk32("b2b T2 mem_addr", mem_addr, 32'h184);
        chk1("b2b T2 busy", busy, 1'b1);
        tick();
        clear_reqs();
        mem_rdata = 32'hA5A50002;
        #1;
        chk1("b2b T3 busy", busy, 1'b1);
        chk1("b2b T3 if_rvalid", if_rvalid, 1'b0);
        tick();
        chk1("b2b T4 if_rvalid", if_rvalid, 1'b1);
        chk32("b2b T4 if_rdata", if_rdata, 32'hA5A50002);
        tick();
        chk1("b2b T5 busy", busy, 1'b0);

        // Continuous contention: grants every MEM_LAT cycles in the policy order.
        if_req    = 1'b1;
        ls_req    = 1'b1;
        ls_we     = 1'b0;
        if_addr   = 32'h500;
        ls_addr   = 32'h600;
        mem_rdata = 32'hCAFE0001;
        #1;
        for (int k = 0; k < 10; k++) begin
            exp_ls = seq_ls[k];
            chk1($sformatf("cont%0d ls_gnt", k), ls_gnt, exp_ls);
            chk1($sformatf("cont%0d if_gnt", k), if_gnt, !exp_ls);
            chk32($sformatf("cont%0d mem_addr", k), mem_addr, exp_ls ? 32'h600 : 32'h500);
            chk1($sformatf("cont%0d addr_sel", k), addr_sel, exp_ls);
            if (k > 0) begin
                chk1($sformatf("cont%0d ls_rvalid", k), ls_rvalid, seq_ls[k-1]);
                chk1($sformatf("cont%0d if_rvalid", k), if_rvalid, !seq_ls[k-1]);
            end
            tick();
            chk1($sformatf("cont%0d gap mem_en", k), mem_en, 1'b0);
            chk1($sformatf("cont%0d gap busy", k), busy, 1'b1);
            tick();
        end
        clear_reqs();
        #1;
        chk1("cont end if_rvalid", if_rvalid, 1'b1);
        chk32("cont end if_rdata", if_rdata, 32'hCAFE0001);
        chk1("cont end mem_en", mem_en, 1'b0);
        tick();
        chk1("cont idle busy", busy, 1'b0);

        // Reset while an IF access is in flight.
        if_req  = 1'b1;
        if_addr = 32'h200;
        #1;
        chk1("rstw T0 if_gnt", if_gnt, 1'b1);
        tick();
        if_req = 1'b0;
        rst_n  = 1'b0;
        #1;
        chk1("rstw T1 busy", busy, 1'b0);
        chk1("rstw T1 if_rvalid", if_rvalid, 1'b0);
        chk1("rstw T1 addr_sel", addr_sel, 1'b0);
        chk1("rstw T1 mem_en", mem_en, 1'b0);
        tick();
        chk1("rstw T2 if_rvalid", if_rvalid, 1'b0);
        chk32("rstw T2 if_rdata", if_rdata, 32'h0);
        rst_n = 1'b1;
        tick();
        chk1("rstw T3 if_rvalid", if_rvalid, 1'b0);
        chk1("rstw T3 busy", busy, 1'b0);
        if_req    = 1'b1;
        if_addr   = 32'h300;
        mem_rdata = 32'h0BADF00D;
        #1;
        chk1("rstw T3 if_gnt", if_gnt, 1'b1);
        chk32("rstw T3 mem_addr", mem_addr, 32'h300);
        tick();
        if_req = 1'b0;
        tick();
        chk1("rstw T5 if_rvalid", if_rvalid, 1'b1);
        chk32("rstw T5 if_rdata", if_rdata, 32'h0BADF00D);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_mem_port_arbiter
